// File: rtl/booth_pp_gen_16.sv
// Radix-4 Booth partial-product generator: 16x16 signed operands to eight 33-bit rows, 2-stage valid/ready pipeline.
// Optional macro BOOTH_ZERO_GATE_EN clears the row registers for zero operands and adds the zero_flag output.
module booth_pp_gen_16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [32:0] p1,
   output logic [32:0] p2,
   output logic [32:0] p3,
   output logic [32:0] p4,
   output logic [32:0] p5,
   output logic [32:0] p6,
   output logic [32:0] p7,
   output logic [32:0] p8
`ifdef BOOTH_ZERO_GATE_EN
   ,
   output logic        zero_flag
`endif
);

   logic        s1_valid_q, s1_valid_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic        out_valid_q, out_valid_d;
   logic [32:0] p_q [8];
   logic [32:0] p_d [8];
   logic [32:0] enc_row [8];
   logic [32:0] a_ext;
   logic [16:0] b_ext;
   logic        s2_loads;
   logic        accept;
`ifdef BOOTH_ZERO_GATE_EN
   logic        zero_flag_q, zero_flag_d;
`endif

   // Row magnitude for one Booth digit; the full two's complement negation stays inside the 33-bit row.
   function automatic logic [32:0] booth_row(input logic [32:0] m, input logic [2:0] triple);
      logic [32:0] r;
      unique case (triple)
         3'b001, 3'b010: r = m;
         3'b011:         r = m << 1;
         3'b100:         r = 33'd0 - (m << 1);
         3'b101, 3'b110: r = 33'd0 - m;
         default:        r = '0;
      endcase
      return r;
   endfunction

   always_comb begin
      s2_loads = s1_valid_q && (!out_valid_q || out_ready);
      in_ready = !s1_valid_q || s2_loads;
      accept   = in_valid && in_ready;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      a_d        = a_q;
      b_d        = b_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         a_d        = a;
         b_d        = b;
      end else if (s2_loads) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      a_ext = {{17{a_q[15]}}, a_q};
      b_ext = {b_q, 1'b0};
      for (int k = 0; k < 8; k++) begin
         enc_row[k] = booth_row(a_ext, b_ext[2*k +: 3]) << (2*k);
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      for (int k = 0; k < 8; k++) begin
         p_d[k] = p_q[k];
      end
`ifdef BOOTH_ZERO_GATE_EN
      zero_flag_d = zero_flag_q;
`endif
      if (s2_loads) begin
         out_valid_d = 1'b1;
`ifdef BOOTH_ZERO_GATE_EN
         // Zero operands skip the encoder; rows already at zero are left untouched.
         if (a_q == 16'd0 || b_q == 16'd0) begin
            zero_flag_d = 1'b1;
            for (int k = 0; k < 8; k++) begin
               if (p_q[k] != 33'd0) begin
                  p_d[k] = '0;
               end
            end
         end else begin
            zero_flag_d = 1'b0;
            for (int k = 0; k < 8; k++) begin
               p_d[k] = enc_row[k];
            end
         end
`else
         for (int k = 0; k < 8; k++) begin
            p_d[k] = enc_row[k];
         end
`endif
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         out_valid_q <= 1'b0;
         for (int k = 0; k < 8; k++) begin
            p_q[k] <= '0;
         end
`ifdef BOOTH_ZERO_GATE_EN
         zero_flag_q <= 1'b0;
`endif
      end else begin
         s1_valid_q  <= s1_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         out_valid_q <= out_valid_d;
         for (int k = 0; k < 8; k++) begin
            p_q[k] <= p_d[k];
         end
`ifdef BOOTH_ZERO_GATE_EN
         zero_flag_q <= zero_flag_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign p1 = p_q[0];
   assign p2 = p_q[1];
   assign p3 = p_q[2];
   assign p4 = p_q[3];
   assign p5 = p_q[4];
   assign p6 = p_q[5];
   assign p7 = p_q[6];
   assign p8 = p_q[7];
`ifdef BOOTH_ZERO_GATE_EN
   assign zero_flag = zero_flag_q;
`endif

endmodule

// File: tb/tb_booth_pp_gen_16.sv
// Scoreboard bench for booth_pp_gen_16: arithmetic Booth-digit model, row-sum vs product check, backpressure and reset cases.
module tb_booth_pp_gen_16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [32:0] p1, p2, p3, p4, p5, p6, p7, p8;
`ifdef BOOTH_ZERO_GATE_EN
   logic        zero_flag;
`endif

   always #5 clk = ~clk;

   booth_pp_gen_16 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p1        (p1),
      .p2        (p2),
      .p3        (p3),
      .p4        (p4),
      .p5        (p5),
      .p6        (p6),
      .p7        (p7),
      .p8        (p8)
`ifdef BOOTH_ZERO_GATE_EN
      ,
      .zero_flag (zero_flag)
`endif
   );

   typedef struct packed {
      logic [263:0] rows;
      logic [31:0]  prod;
      logic         zf;
   } exp_t;

   exp_t         sb[$];
   int           totalChecks = 0;
   int           badChecks = 0;
   logic [263:0] gotRows;
   bit           holdValid = 1'b0;
   logic [263:0] holdRows;
   bit           drvDone;

   assign gotRows = {p8, p7, p6, p5, p4, p3, p2, p1};

   task automatic checkOutput(input string tag, input logic [263:0] got, input logic [263:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Rows from the integer digit value times a, independent of any bit-pattern encoding.
   function automatic logic [263:0] modelRows(input logic [15:0] av, input logic [15:0] bv);
      logic [263:0] r;
      logic [16:0]  bx;
      longint       d;
      longint       row;
      r  = '0;
      bx = {bv, 1'b0};
      for (int k = 0; k < 8; k++) begin
         d   = longint'(bx[2*k+1]) + longint'(bx[2*k]) - 2 * longint'(bx[2*k+2]);
         row = (d * longint'($signed(av))) << (2*k);
         r[33*k +: 33] = row[32:0];
      end
      return r;
   endfunction

   function automatic exp_t modelEntry(input logic [15:0] av, input logic [15:0] bv);
      exp_t   e;
      longint pr;
      pr     = longint'($signed(av)) * longint'($signed(bv));
      e.rows = modelRows(av, bv);
      e.prod = pr[31:0];
      e.zf   = (av == 16'd0) || (bv == 16'd0);
      return e;
   endfunction

   function automatic logic [31:0] sumRows(input logic [263:0] r);
      logic [31:0] s;
      s = '0;
      for (int k = 0; k < 8; k++) begin
         s = s + r[33*k +: 32];
      end
      return s;
   endfunction

   task automatic monitorStep();
      exp_t e;
      if (!rst_n) begin
         sb.delete();
         holdValid = 1'b0;
         return;
      end
      if (holdValid) begin
         checkOutput("hold_valid", out_valid, 1);
         checkOutput("hold_rows", gotRows, holdRows);
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checkOutput("stale_emit", 1, 0);
         end else begin
            e = sb.pop_front();
            checkOutput("rows", gotRows, e.rows);
            checkOutput("sum", sumRows(gotRows), e.prod);
`ifdef BOOTH_ZERO_GATE_EN
            checkOutput("zero_flag", zero_flag, e.zf);
`endif
         end
      end
      holdValid = out_valid && !out_ready;
      holdRows  = gotRows;
      if (in_valid && in_ready) begin
         sb.push_back(modelEntry(a, b));
      end
   endtask

   always @(negedge clk) monitorStep();

   task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv);
      bit acc;
      acc      = 1'b0;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         if (in_ready) acc = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      checkOutput("accept", acc, 1);
   endtask

   task automatic waitDrain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid) done = 1'b1;
      end
      checkOutput("drain", done, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic checkDirected(input string tag, input logic [15:0] av, input logic [15:0] bv,
                                input logic [263:0] expRows);
      applyStimulus(av, bv);
      @(negedge clk);
      checkOutput({tag, "_lat1"}, out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_lat2"}, out_valid, 1);
      checkOutput(tag, gotRows, expRows);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog got=running want=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [263:0] r;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      drvDone   = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_valid", out_valid, 0);
      checkOutput("rst_rows", gotRows, 0);
      checkOutput("rst_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      r = '0; r[32:0] = 33'd3; r[65:33] = 33'd12;
      checkDirected("mul_3x5", 16'd3, 16'd5, r);
      r = '0; r[32:0] = 33'd1;
      checkDirected("neg1_sq", 16'hFFFF, 16'hFFFF, r);
      r = '0; r[263:231] = 33'h0_4000_0000;
      checkDirected("minneg_sq", 16'h8000, 16'h8000, r);
      r = '0; r[32:0] = 33'h0_0001_0000; r[65:33] = 33'h1_FFFE_0000;
      checkDirected("minneg_d0", 16'h8000, 16'h0002, r);

      // Backpressure: two pairs fill both stages, then in_ready must drop.
      out_ready = 1'b0;
      applyStimulus(16'd7, 16'd9);
      applyStimulus(16'hFFF0, 16'd300);
      @(negedge clk);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
      fork
         begin
            applyStimulus(16'h1234, 16'hABCD);
            applyStimulus(16'h7FFF, 16'h8000);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      waitDrain();

      // Reset with both stages full must discard everything.
      out_ready = 1'b0;
      applyStimulus(16'd11, 16'd13);
      applyStimulus(16'd17, 16'd19);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rstmid_valid", out_valid, 0);
      checkOutput("rstmid_rows", gotRows, 0);
      checkOutput("rstmid_ready", in_ready, 1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      checkOutput("rstmid_idle", out_valid, 0);
      @(posedge clk);
      #1;

      fork
         begin
            logic [15:0] ra, rb;
            for (int i = 0; i < 400; i++) begin
               ra = 16'($urandom);
               rb = 16'($urandom);
               if ($urandom_range(0, 9) == 0) ra = 16'd0;
               if ($urandom_range(0, 9) == 0) rb = 16'd0;
               if ($urandom_range(0, 15) == 0) ra = 16'h8000;
               applyStimulus(ra, rb);
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
            end
            drvDone = 1'b1;
         end
         begin
            while (!drvDone) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      waitDrain();

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
